// File: rtl/hash_des_sbox_ctrl_if.sv
// Byte-source, S-box and digest signals of the DES-S-box lane hash controller.
// master: the byte source / S-box side; slave: the controller itself.
interface hash_des_sbox_ctrl_if;
   logic        start;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_last;
   logic        flush;
   logic        m_ready;
   logic [5:0]  sbox_in;
   logic [3:0]  sbox_out;
   logic [31:0] digest_out;
   logic        hash_ready;
   logic        busy;

   modport master (
      output start, m_valid, m_data, m_last, flush, sbox_out,
      input  m_ready, sbox_in, digest_out, hash_ready, busy
   );

   modport slave (
      input  start, m_valid, m_data, m_last, flush, sbox_out,
      output m_ready, sbox_in, digest_out, hash_ready, busy
   );
endinterface

// File: rtl/hash_des_sbox_ctrl.sv
// Sequential controller for the DES-S-box 4-bit-lane hash.
// Accepts message bytes, runs ROUNDS lane rounds per byte through one shared
// S-box, then folds the 64-bit byte count in (MSB byte first) and presents
// the 32-bit digest {H[0],...,H[7]}.
module hash_des_sbox_ctrl #(
   parameter logic [31:0] IV     = 32'h4B71DF03,
   parameter int          ROUNDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   hash_des_sbox_ctrl_if.slave   bus
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_BYTE  = 3'd1;
   localparam logic [2:0] S_LOOKUP     = 3'd2;
   localparam logic [2:0] S_ROUND      = 3'd3;
   localparam logic [2:0] S_FIN_LOOKUP = 3'd4;
   localparam logic [2:0] S_FIN_ROUND  = 3'd5;
   localparam logic [2:0] S_DONE       = 3'd6;

   localparam logic [2:0] ROUNDS_L = 3'(ROUNDS);

   logic [2:0]  state_q,  state_d;
   logic [31:0] h_q,      h_d;
   logic [63:0] cnt_q,    cnt_d;
   logic [3:0]  s_q,      s_d;
   logic [7:0]  msg_q,    msg_d;
   logic        last_q,   last_d;
   logic [2:0]  r_q,      r_d;
   logic [2:0]  k_q,      k_d;
   logic [31:0] digest_q, digest_d;

   logic [5:0]  sbox_idx;
   logic [7:0]  cnt_byte;
   logic [31:0] round_h;
   logic [3:0]  lane_src;

   function automatic logic [3:0] rotl4(input logic [3:0] x, input int amt);
      case (amt)
         1:       rotl4 = {x[2:0], x[3]};
         2:       rotl4 = {x[1:0], x[3:2]};
         3:       rotl4 = {x[0], x[3:1]};
         default: rotl4 = x;
      endcase
   endfunction

   // S-box index: message mix in LOOKUP, count-byte mix in FIN_LOOKUP, else 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      sbox_idx = '0;
      cnt_byte = cnt_q[{3'd7 - k_q, 3'b000} +: 8];
      case (state_q)
         S_LOOKUP:     sbox_idx = {msg_q[3] ^ msg_q[2], msg_q[1], msg_q[0],
                                   msg_q[7], msg_q[6], msg_q[5] ^ msg_q[4]};
         S_FIN_LOOKUP: sbox_idx = {cnt_byte[7] ^ cnt_byte[1], cnt_byte[3], cnt_byte[2],
                                   cnt_byte[5] ^ cnt_byte[0], cnt_byte[4], cnt_byte[6]};
         default:      sbox_idx = '0;
      endcase
   end

   // One lane round: H'[i] = rotl4(H[(i+1) mod 8] ^ S, i/2); H[0] is the top nibble.
   always_comb begin
      round_h  = '0;
      lane_src = '0;
      for (int i = 0; i < 8; i++) begin
         lane_src = h_q[28 - 4 * ((i + 1) % 8) +: 4] ^ s_q;
         round_h[28 - 4 * i +: 4] = rotl4(lane_src, i / 2);
      end
   end

   // Next-state and datapath control; start overrides everything, including a
   // same-cycle byte acceptance.
   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      msg_d    = msg_q;
      last_d   = last_q;
      r_d      = r_q;
      k_d      = k_q;
      digest_d = digest_q;
      if (bus.start) begin
         state_d  = S_WAIT_BYTE;
         h_d      = IV;
         cnt_d    = '0;
         r_d      = '0;
         k_d      = '0;
         digest_d = '0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_WAIT_BYTE: begin
               if (bus.m_valid) begin
                  msg_d   = bus.m_data;
                  last_d  = bus.m_last;
                  cnt_d   = cnt_q + 64'd1;
                  state_d = S_LOOKUP;
               end else if (bus.flush) begin
                  k_d     = '0;
                  state_d = S_FIN_LOOKUP;
               end
            end
            S_LOOKUP: begin
               s_d     = bus.sbox_out;
               r_d     = '0;
               state_d = S_ROUND;
            end
            S_ROUND: begin
               // Rounds run while r < ROUNDS; the cycle with r == ROUNDS only
               // hands over to the next phase.
               if (r_q < ROUNDS_L) begin
                  h_d = round_h;
                  r_d = r_q + 3'd1;
               end else if (last_q) begin
                  k_d     = '0;
                  state_d = S_FIN_LOOKUP;
               end else begin
                  state_d = S_WAIT_BYTE;
               end
            end
            S_FIN_LOOKUP: begin
               s_d     = bus.sbox_out;
               state_d = S_FIN_ROUND;
            end
            S_FIN_ROUND: begin
               h_d = round_h;
               if (k_q == 3'd7) begin
                  digest_d = round_h;
                  state_d  = S_DONE;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = S_FIN_LOOKUP;
               end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and hash registers; reset discards any hash in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         h_q      <= IV;
         cnt_q    <= '0;
         s_q      <= '0;
         msg_q    <= '0;
         last_q   <= 1'b0;
         r_q      <= '0;
         k_q      <= '0;
         digest_q <= '0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples
         // the pre-edge values regardless of statement order.
         state_q  <= state_d;
         h_q      <= h_d;
         cnt_q    <= cnt_d;
         s_q      <= s_d;
         msg_q    <= msg_d;
         last_q   <= last_d;
         r_q      <= r_d;
         k_q      <= k_d;
         digest_q <= digest_d;
      end
   end

   assign bus.m_ready    = (state_q == S_WAIT_BYTE);
   assign bus.sbox_in    = sbox_idx;
   assign bus.digest_out = digest_q;
   assign bus.hash_ready = (state_q == S_DONE);
   assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_hash_des_sbox_ctrl.sv
// Scoreboard bench for hash_des_sbox_ctrl: stimulus pushes reference digests,
// a negedge monitor checks handshake timing, S-box indices and digests.
module tb_hash_des_sbox_ctrl;

   localparam logic [31:0] IV     = 32'h4B71DF03;
   localparam int          ROUNDS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sbox_zero = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   hash_des_sbox_ctrl_if bus ();

   hash_des_sbox_ctrl #(.IV(IV), .ROUNDS(ROUNDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DES S1, row = {b5,b0}, column = b4..b1.
   logic [3:0] s1_tab [64] = '{
      4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
      4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
      4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
      4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13};

   function automatic logic [3:0] sb(input logic [5:0] idx, input logic zero);
      int row, col;
      row = {idx[5], idx[0]};
      col = idx[4:1];
      return zero ? 4'h0 : s1_tab[row * 16 + col];
   endfunction

   assign bus.sbox_out = sb(bus.sbox_in, sbox_zero);

   function automatic logic [5:0] m6(input logic [7:0] m);
      return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
   endfunction

   function automatic logic [5:0] c6(input logic [7:0] c);
      return {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
   endfunction

   // Reference round on an array of eight lanes.
   function automatic logic [31:0] rnd(input logic [31:0] h, input logic [3:0] s);
      logic [3:0]  lane [8];
      logic [7:0]  dbl;
      logic [31:0] res;
      for (int i = 0; i < 8; i++) lane[i] = 4'(h >> (28 - 4 * i));
      res = '0;
      for (int i = 0; i < 8; i++) begin
         dbl = {lane[(i + 1) % 8] ^ s, lane[(i + 1) % 8] ^ s} << (i / 2);
         res = (res << 4) | 32'(dbl[7:4]);
      end
      return res;
   endfunction

   function automatic logic [31:0] model(input logic [7:0] msg[$], input logic zero);
      logic [31:0] h;
      logic [63:0] len;
      logic [3:0]  s;
      h   = IV;
      len = 64'(msg.size());
      foreach (msg[j]) begin
         s = sb(m6(msg[j]), zero);
         for (int r = 0; r < ROUNDS; r++) h = rnd(h, s);
      end
      for (int k = 0; k < 8; k++) h = rnd(h, sb(c6(8'(len >> (56 - 8 * k))), zero));
      return h;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [31:0] exp_q [$];
   logic [31:0] exp_cur = '0;
   logic        prev_ready = 1'b0;
   logic        lk_pend = 1'b0;
   logic [7:0]  lk_byte = '0;
   logic        pend_gap = 1'b0;
   int          low_run = 0;
   logic        fin_active = 1'b0;
   int          fin_base = 0;
   int          last_acc_edge = -1;
   logic [63:0] mon_len = '0;

   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         prev_ready = 1'b0; lk_pend = 1'b0; pend_gap = 1'b0;
         fin_active = 1'b0; mon_len = '0; last_acc_edge = -1;
      end else begin
         if (lk_pend) begin
            check("lookup_sbox_in", bus.sbox_in, m6(lk_byte));
            lk_pend = 1'b0;
         end
         if (pend_gap) begin
            if (!bus.m_ready) low_run++;
            else begin
               check("m_ready_low_cycles", low_run, ROUNDS + 2);
               pend_gap = 1'b0;
            end
         end
         if (fin_active && cyc >= fin_base && cyc < fin_base + 16) begin
            if (((cyc - fin_base) % 2) == 0)
               check("fin_sbox_in", bus.sbox_in,
                     c6(8'(mon_len >> (56 - 8 * ((cyc - fin_base) / 2)))));
            else
               check("fin_round_sbox_in", bus.sbox_in, 0);
         end
         if (bus.hash_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL digest_unexpected actual=%0h expected=none", bus.digest_out);
            end else begin
               exp_cur = exp_q.pop_front();
               check("digest", bus.digest_out, exp_cur);
               if (last_acc_edge >= 0) check("ready_latency", cyc - last_acc_edge, ROUNDS + 18);
               else                    check("flush_latency", cyc - fin_base, 16);
               check("busy_done", bus.busy, 0);
            end
         end else if (bus.hash_ready) begin
            check("digest_hold", bus.digest_out, exp_cur);
         end else if (prev_ready) begin
            check("digest_cleared", bus.digest_out, 0);
         end
         prev_ready = bus.hash_ready;
         if (bus.start) begin
            mon_len = '0; fin_active = 1'b0; pend_gap = 1'b0; lk_pend = 1'b0;
         end else if (bus.m_ready && bus.m_valid) begin
            mon_len++;
            lk_pend = 1'b1;
            lk_byte = bus.m_data;
            if (bus.m_last) begin
               last_acc_edge = cyc + 1;
               fin_base      = cyc + 1 + ROUNDS + 2;
               fin_active    = 1'b1;
            end else begin
               pend_gap = 1'b1;
               low_run  = 0;
            end
         end else if (bus.m_ready && bus.flush) begin
            last_acc_edge = -1;
            fin_base      = cyc + 1;
            fin_active    = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers (enter and leave just after a negedge) ----------------
   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_m_ready();
      int n = 0;
      while (!bus.m_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("m_ready_timeout", 0, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input logic with_flush);
      wait_m_ready();
      bus.m_valid = 1'b1; bus.m_data = b; bus.m_last = last; bus.flush = with_flush;
      @(negedge clk);
      bus.m_valid = 1'b0; bus.m_last = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic send_flush();
      wait_m_ready();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.hash_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("hash_ready_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_msg(input logic [7:0] msg[$], input logic random_gaps);
      exp_q.push_back(model(msg, sbox_zero));
      pulse_start();
      if (msg.size() == 0) send_flush();
      foreach (msg[j]) begin
         if (random_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_byte(msg[j], j == msg.size() - 1,
                   random_gaps && (j != msg.size() - 1) && ($urandom_range(0, 1) == 1));
      end
      wait_ready();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] msg [$];
      logic [7:0] bp [4];
      bus.start = 1'b0; bus.m_valid = 1'b0; bus.m_data = '0;
      bus.m_last = 1'b0; bus.flush = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_m_ready", bus.m_ready, 0);
      check("rst_sbox_in", bus.sbox_in, 0);
      check("rst_digest", bus.digest_out, 0);
      check("rst_hash_ready", bus.hash_ready, 0);
      check("rst_busy", bus.busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of the ROUND phase.
      pulse_start();
      send_byte(8'h5A, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_m_ready", bus.m_ready, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_sbox_in", bus.sbox_in, 0);
      check("midrst_hash_ready", bus.hash_ready, 0);
      check("midrst_digest", bus.digest_out, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_m_ready", bus.m_ready, 0);
      check("idle_busy", bus.busy, 0);

      // Single byte 0x61, then "abc".
      msg = '{8'h61};
      run_msg(msg, 1'b0);
      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(msg, 1'b0);

      // Zero S-box, empty message: rotations and lane order only.
      sbox_zero = 1'b1;
      msg = {};
      run_msg(msg, 1'b0);
      sbox_zero = 1'b0;

      // Back-pressure: m_valid held high across four bytes.
      bp = '{8'h10, 8'hFE, 8'h00, 8'h9C};
      msg = '{8'h10, 8'hFE, 8'h00, 8'h9C};
      exp_q.push_back(model(msg, 1'b0));
      pulse_start();
      bus.m_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_m_ready();
         bus.m_data = bp[i];
         bus.m_last = (i == 3);
         @(negedge clk);
      end
      bus.m_valid = 1'b0; bus.m_last = 1'b0;
      wait_ready();
      check("bp_byte_count", mon_len, 4);

      // start during FIN_ROUND aborts the hash.
      pulse_start();
      send_byte(8'hC3, 1'b1, 1'b0);
      repeat (ROUNDS + 3) @(negedge clk);
      pulse_start();
      check("abort_hash_ready", bus.hash_ready, 0);
      check("abort_m_ready", bus.m_ready, 1);
      check("abort_digest", bus.digest_out, 0);
      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(msg, 1'b0);

      // start together with m_valid in WAIT_BYTE: byte is not taken.
      pulse_start();
      bus.start = 1'b1; bus.m_valid = 1'b1; bus.m_data = 8'h77; bus.m_last = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.m_valid = 1'b0; bus.m_last = 1'b0;
      check("start_valid_m_ready", bus.m_ready, 1);
      check("start_valid_busy", bus.busy, 1);
      msg = '{8'h61, 8'h62};
      run_msg(msg, 1'b0);

      // Randomized messages, lengths 0..5, random gaps and flush overlap.
      for (int n = 0; n < 12; n++) begin
         msg = {};
         repeat ($urandom_range(0, 5)) msg.push_back(8'($urandom));
         run_msg(msg, 1'b1);
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
